// File: rtl/register_file_pkg.sv
// Shared CPU definitions: datapath width, register addressing and write-back source encoding.
package register_file_pkg;

    localparam int DataWidth    = 32;
    localparam int RegAddrWidth = 5;

    typedef logic [RegAddrWidth-1:0] reg_addr_t;

    localparam reg_addr_t ZeroReg = 5'd0;

    typedef enum logic [1:0] {
        ALUResult              = 2'd0,
        Memory                 = 2'd1,
        NextInstructionAddress = 2'd3
    } reg_write_source_e;

endpackage

// File: rtl/register_file_if.sv
// Register file port bundle: write-back, operand reads, issue scoreboard and debug read.
interface register_file_if #(
    parameter int DataWidth = 32
);
    import register_file_pkg::*;

    logic                 write_enable;
    reg_addr_t            write_address;
    logic [DataWidth-1:0] write_data;
    reg_addr_t            read_address1;
    reg_addr_t            read_address2;
    logic [DataWidth-1:0] read_data1;
    logic [DataWidth-1:0] read_data2;
    logic                 busy_set_enable;
    reg_addr_t            busy_set_address;
    logic                 read_busy1;
    logic                 read_busy2;
    reg_addr_t            debug_read_address;
    logic [DataWidth-1:0] debug_read_data;

    modport master (
        output write_enable, write_address, write_data,
        output read_address1, read_address2,
        output busy_set_enable, busy_set_address,
        output debug_read_address,
        input  read_data1, read_data2, read_busy1, read_busy2, debug_read_data
    );

    modport slave (
        input  write_enable, write_address, write_data,
        input  read_address1, read_address2,
        input  busy_set_enable, busy_set_address,
        input  debug_read_address,
        output read_data1, read_data2, read_busy1, read_busy2, debug_read_data
    );

endinterface

// File: rtl/register_file.sv
// Integer register file with write-first bypass on both operand ports and a
// per-register busy scoreboard tracking in-flight producers.
module register_file #(
    parameter int DataWidth = register_file_pkg::DataWidth,
    parameter int RegCount  = 32
) (
    input  logic           clock,
    input  logic           reset_n,
    register_file_if.slave rf
);
    import register_file_pkg::*;

    localparam logic [RegCount-1:0] Bit0 = {{(RegCount-1){1'b0}}, 1'b1};

    logic [DataWidth-1:0] regs_q [RegCount];
    logic [RegCount-1:0]  busy_q;
    logic [RegCount-1:0]  busy_d;
    logic                 wr_valid_s;
    logic [RegCount-1:0]  set_vec_s;
    logic [RegCount-1:0]  clr_vec_s;

    assign wr_valid_s = rf.write_enable && (rf.write_address != ZeroReg);

    // Decode set/clear one-hots; set is applied last so a newer producer wins.
    always_comb begin
        set_vec_s = '0;
        clr_vec_s = '0;
        if (rf.busy_set_enable) begin
            set_vec_s = Bit0 << rf.busy_set_address;
        end else begin
            set_vec_s = '0;
        end
        if (wr_valid_s) begin
            clr_vec_s = Bit0 << rf.write_address;
        end else begin
            clr_vec_s = '0;
        end
        busy_d = ((busy_q & ~clr_vec_s) | set_vec_s) & ~Bit0;
    end

    // Register array; x0 is never written so it stays zero from reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RegCount; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_valid_s) begin
            regs_q[rf.write_address] <= rf.write_data;
        end
    end

    // Scoreboard state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Operand port 1: x0 forced to zero, then same-cycle write-back bypass.
    always_comb begin
        rf.read_data1 = regs_q[rf.read_address1];
        rf.read_busy1 = busy_q[rf.read_address1];
        if (rf.read_address1 == ZeroReg) begin
            rf.read_data1 = '0;
            rf.read_busy1 = 1'b0;
        end else if (wr_valid_s && (rf.write_address == rf.read_address1)) begin
            rf.read_data1 = rf.write_data;
            rf.read_busy1 = 1'b0;
        end else begin
            rf.read_data1 = regs_q[rf.read_address1];
            rf.read_busy1 = busy_q[rf.read_address1];
        end
    end

    // Operand port 2: same rules as port 1.
    always_comb begin
        rf.read_data2 = regs_q[rf.read_address2];
        rf.read_busy2 = busy_q[rf.read_address2];
        if (rf.read_address2 == ZeroReg) begin
            rf.read_data2 = '0;
            rf.read_busy2 = 1'b0;
        end else if (wr_valid_s && (rf.write_address == rf.read_address2)) begin
            rf.read_data2 = rf.write_data;
            rf.read_busy2 = 1'b0;
        end else begin
            rf.read_data2 = regs_q[rf.read_address2];
            rf.read_busy2 = busy_q[rf.read_address2];
        end
    end

    assign rf.debug_read_data = regs_q[rf.debug_read_address];

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DataWidth, default 32, register and data width in bits.
REQ-002 Parameter RegCount, default 32, number of architectural registers; the register address is 5 bits wide.
REQ-003 Port clock, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port write_enable, input, 1 bit: write-back strobe from the WB stage.
REQ-006 Port write_address, input, 5 bits: write-back destination register.
REQ-007 Port write_data, input, DataWidth bits: write-back value (ALU result, memory data or PC+4).
REQ-008 Port read_address1 and read_address2, input, 5 bits each: decode-stage source register addresses.
REQ-009 Port read_data1 and read_data2, output, DataWidth bits each: source operand values.
REQ-010 Port busy_set_enable, input, 1 bit: an issued instruction will write register busy_set_address.
REQ-011 Port busy_set_address, input, 5 bits: destination register of the issuing instruction.
REQ-012 Port read_busy1 and read_busy2, output, 1 bit each: the matching source register has a pending write.
REQ-013 Port debug_read_address, input, 5 bits: register selected for inspection by the bench or debugger.
REQ-014 Port debug_read_data, output, DataWidth bits: raw stored value of the debug register.

Function
REQ-015 On each rising clock edge with write_enable=1 and write_address!=0, the register array SHALL store write_data.
REQ-016 Writes to x0 SHALL be ignored, and x0 SHALL always read 0 on every read port.
REQ-017 Read ports SHALL be combinational, with zero-cycle latency.
REQ-018 A read in the same cycle as a write to the same nonzero address SHALL return write_data (write-first bypass); this applies to each port independently.
REQ-019 debug_read_data SHALL return the stored array value with no bypass.
REQ-020 The scoreboard SHALL hold one busy bit per register; bit 0 SHALL be constant 0.
REQ-021 On a clock edge, busy_set_enable=1 with a nonzero busy_set_address SHALL set that register's busy bit.
REQ-022 On a clock edge, write_enable=1 with a nonzero write_address SHALL clear that register's busy bit.
REQ-023 If a set and a clear target the same register on the same edge, set SHALL win, because a newer producer is in flight.
REQ-024 read_busyN SHALL equal busy[read_addressN] AND NOT (write_enable AND write_address==read_addressN), which matches the data bypass.
REQ-025 Sets and clears to different registers on the same edge SHALL both take effect.

Reset
REQ-026 While reset_n=0, all registers and all busy bits SHALL be 0, regardless of clock.
REQ-027 After reset, read_data1, read_data2 and debug_read_data SHALL be 0 for every address, and read_busy1 and read_busy2 SHALL be 0, until the first write.
REQ-028 A reset asserted during a write cycle SHALL discard that write.
REQ-029 Reset deassertion SHALL be synchronized externally; the first edge after deassertion SHALL act as a normal cycle.

Structure
REQ-030 DataWidth, the register address width (5), and the zero-register constant SHALL live in the shared CPU package, together with the RegWriteSource encoding (ALUResult=0, Memory=1, NextInstructionAddress=3).
REQ-031 The module SHALL be a single module with no sub-modules; the register array and the scoreboard are internal vectors.

Verification
REQ-032 Reset then read all 32 addresses on all three read ports -> 0 returned, and both busy flags 0.
REQ-033 Write x5=0xDEADBEEF; in the same cycle read_address1=5 -> read_data1=0xDEADBEEF and debug_read_data = old value 0; next cycle debug_read_data=0xDEADBEEF.
REQ-034 Write x0=0x12345678, then read_address2=0 -> read_data2=0; set busy on x0 -> read_busy2 stays 0.
REQ-035 Set busy on x7, then read_address1=7 -> read_busy1=1; a WB write to x7 in a later cycle -> read_busy1=0 combinationally in that cycle and 0 after the edge.
REQ-036 Same edge: busy set on x9 and WB write to x9=0x55 -> x9 reads 0x55 and read_busy=1 afterwards.
REQ-037 Pulse reset_n low mid-cycle while write_enable=1 targets x3 -> x3=0 and all busy bits 0 immediately, with no clock edge required.
